// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_if
// Brief    : Memory-stage to writeback bundle plus register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_stage_if #(
    parameter int RETIRE_WIDTH = 64
);
    logic                    valid_in;
    logic [4:0]              rd_address_in;
    logic [31:0]             result_in;
    logic                    load_in;
    logic [2:0]              load_funct3;
    logic [1:0]              load_addr_lsb;
    logic                    mem_rvalid;
    logic [31:0]             mem_rdata;
    logic                    busy_out;
    logic [4:0]              rd_address;
    logic [31:0]             rd_data;
    logic [RETIRE_WIDTH-1:0] instret;

    modport master (
        output valid_in, rd_address_in, result_in, load_in, load_funct3,
               load_addr_lsb, mem_rvalid, mem_rdata,
        input  busy_out, rd_address, rd_data, instret
    );

    modport slave (
        input  valid_in, rd_address_in, result_in, load_in, load_funct3,
               load_addr_lsb, mem_rvalid, mem_rdata,
        output busy_out, rd_address, rd_data, instret
    );
endinterface
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : Final pipeline stage; waits for late loads, extends load data and
//            drives the register-file write port. Optional counter gated by
//            macro RETIRE_COUNTER_EN (undefined: instret tied to 0).
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int RETIRE_WIDTH = 64
) (
    input  wire logic         clk,
    input  wire logic         reset,
    writeback_stage_if.slave  wb
);
    typedef enum logic {
        ACCEPT    = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  rd_address_q, rd_address_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic [2:0]  pend_funct3_q, pend_funct3_d;
    logic [1:0]  pend_lsb_q, pend_lsb_d;

    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  lsb
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lsb, 3'b000} +: 8];
        h = lsb[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b100:  extend_load = {24'd0, b};
            3'b101:  extend_load = {16'd0, h};
            default: extend_load = word;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ACCEPT;
            rd_address_q  <= 5'd0;
            rd_data_q     <= 32'd0;
            pend_rd_q     <= 5'd0;
            pend_funct3_q <= 3'd0;
            pend_lsb_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            rd_address_q  <= rd_address_d;
            rd_data_q     <= rd_data_d;
            pend_rd_q     <= pend_rd_d;
            pend_funct3_q <= pend_funct3_d;
            pend_lsb_q    <= pend_lsb_d;
        end
    end

    // rd_address defaults to 0: the register file writes on every edge.
    always_comb begin
        state_d       = state_q;
        rd_address_d  = 5'd0;
        rd_data_d     = rd_data_q;
        pend_rd_d     = pend_rd_q;
        pend_funct3_d = pend_funct3_q;
        pend_lsb_d    = pend_lsb_q;
        case (state_q)
            ACCEPT: begin
                if (wb.valid_in) begin
                    if (!wb.load_in) begin
                        rd_address_d = wb.rd_address_in;
                        rd_data_d    = wb.result_in;
                    end else if (wb.mem_rvalid) begin
                        rd_address_d = wb.rd_address_in;
                        rd_data_d    = extend_load(wb.mem_rdata, wb.load_funct3,
                                                   wb.load_addr_lsb);
                    end else begin
                        pend_rd_d     = wb.rd_address_in;
                        pend_funct3_d = wb.load_funct3;
                        pend_lsb_d    = wb.load_addr_lsb;
                        state_d       = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                if (wb.mem_rvalid) begin
                    rd_address_d = pend_rd_q;
                    rd_data_d    = extend_load(wb.mem_rdata, pend_funct3_q, pend_lsb_q);
                    state_d      = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    assign wb.busy_out   = (state_q == WAIT_LOAD);
    assign wb.rd_address = rd_address_q;
    assign wb.rd_data    = rd_data_q;

`ifdef RETIRE_COUNTER_EN
    logic                    retire;
    logic [RETIRE_WIDTH-1:0] instret_q;

    assign retire = (state_q == ACCEPT    && wb.valid_in && (!wb.load_in || wb.mem_rvalid))
                 || (state_q == WAIT_LOAD && wb.mem_rvalid);

    always_ff @(posedge clk) begin
        if (reset)
            instret_q <= '0;
        else if (retire)
            instret_q <= instret_q + 1'b1;
    end

    assign wb.instret = instret_q;
`else
    assign wb.instret = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Directed self-checking bench for writeback_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;
    logic clk;
    logic reset;
    int   nvec;
    int   nfail;
    int   ret;

    writeback_stage_if #(.RETIRE_WIDTH(4)) wb_if ();

    writeback_stage #(.RETIRE_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_instret();
`ifdef RETIRE_COUNTER_EN
        exp_instret = 4'(ret % 16);
`else
        exp_instret = 4'd0;
`endif
    endfunction

    task automatic drive(input logic v, input logic ld, input logic [4:0] rd,
                         input logic [31:0] res, input logic [2:0] f3,
                         input logic [1:0] lsb, input logic mv, input logic [31:0] md);
        wb_if.valid_in      = v;
        wb_if.load_in       = ld;
        wb_if.rd_address_in = rd;
        wb_if.result_in     = res;
        wb_if.load_funct3   = f3;
        wb_if.load_addr_lsb = lsb;
        wb_if.mem_rvalid    = mv;
        wb_if.mem_rdata     = md;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        ret   = 0;
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_rd_address", 64'(wb_if.rd_address), 64'd0);
            chk("reset_rd_data",    64'(wb_if.rd_data),    64'd0);
            chk("reset_busy",       64'(wb_if.busy_out),   64'd0);
            chk("reset_instret",    64'(wb_if.instret),    64'd0);
        end

        drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 2'd0, 1'b0, 32'd0);
        @(negedge clk); ret++;
        chk("alu_rd_address", 64'(wb_if.rd_address), 64'd5);
        chk("alu_rd_data",    64'(wb_if.rd_data),    64'hDEADBEEF);
        idle();
        @(negedge clk);
        chk("alu_idle_rd_address", 64'(wb_if.rd_address), 64'd0);
        chk("alu_idle_rd_data",    64'(wb_if.rd_data),    64'hDEADBEEF);
        chk("alu_instret",         64'(wb_if.instret),    64'(exp_instret()));

        drive(1'b1, 1'b1, 5'd1, 32'd0, 3'b000, 2'd3, 1'b1, 32'h80FF0000);
        @(negedge clk); ret++;
        chk("lb_rd_address", 64'(wb_if.rd_address), 64'd1);
        chk("lb_rd_data",    64'(wb_if.rd_data),    64'hFFFFFF80);
        drive(1'b1, 1'b1, 5'd2, 32'd0, 3'b101, 2'd2, 1'b1, 32'h80FF0000);
        @(negedge clk); ret++;
        chk("lhu_rd_address", 64'(wb_if.rd_address), 64'd2);
        chk("lhu_rd_data",    64'(wb_if.rd_data),    64'h000080FF);
        drive(1'b1, 1'b1, 5'd3, 32'd0, 3'b001, 2'd2, 1'b1, 32'h80FF0000);
        @(negedge clk); ret++;
        chk("lh_rd_data",  64'(wb_if.rd_data), 64'hFFFF80FF);
        drive(1'b1, 1'b1, 5'd4, 32'd0, 3'b100, 2'd2, 1'b1, 32'h80FF0000);
        @(negedge clk); ret++;
        chk("lbu_rd_data", 64'(wb_if.rd_data), 64'h000000FF);
        drive(1'b1, 1'b1, 5'd6, 32'd0, 3'b011, 2'd0, 1'b1, 32'h80FF0000);
        @(negedge clk); ret++;
        chk("f3_011_rd_data", 64'(wb_if.rd_data), 64'h80FF0000);
        drive(1'b1, 1'b1, 5'd8, 32'd0, 3'b000, 2'd1, 1'b1, 32'h00007F00);
        @(negedge clk); ret++;
        chk("lb_pos_rd_data", 64'(wb_if.rd_data), 64'h0000007F);

        drive(1'b1, 1'b0, 5'd0, 32'h00000001, 3'd0, 2'd0, 1'b0, 32'd0);
        @(negedge clk); ret++;
        chk("rd0_rd_address", 64'(wb_if.rd_address), 64'd0);
        idle();
        @(negedge clk);
        chk("rd0_instret", 64'(wb_if.instret), 64'(exp_instret()));

        // Late LW; valid_in stays high during the wait and must be ignored.
        drive(1'b1, 1'b1, 5'd7, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_busy",       64'(wb_if.busy_out),   64'd1);
            chk("wait_rd_address", 64'(wb_if.rd_address), 64'd0);
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'h12345678);
        @(negedge clk); ret++;
        chk("late_rd_address", 64'(wb_if.rd_address), 64'd7);
        chk("late_rd_data",    64'(wb_if.rd_data),    64'h12345678);
        chk("late_busy",       64'(wb_if.busy_out),   64'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'hCAFEF00D);
        @(negedge clk);
        chk("stray_rvalid_rd_address", 64'(wb_if.rd_address), 64'd0);
        chk("stray_rvalid_rd_data",    64'(wb_if.rd_data),    64'h12345678);
        chk("stray_rvalid_busy",       64'(wb_if.busy_out),   64'd0);
        chk("late_instret",            64'(wb_if.instret),    64'(exp_instret()));

        drive(1'b1, 1'b1, 5'd9, 32'd0, 3'b010, 2'd0, 1'b0, 32'd0);
        @(negedge clk);
        chk("rst_wait_busy", 64'(wb_if.busy_out), 64'd1);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 32'hAAAAAAAA);
        reset = 1'b1;
        @(negedge clk); ret = 0;
        reset = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("rst_wait_rd_address", 64'(wb_if.rd_address), 64'd0);
            chk("rst_wait_busy_low",   64'(wb_if.busy_out),   64'd0);
            chk("rst_wait_instret",    64'(wb_if.instret),    64'd0);
            @(negedge clk);
        end
        chk("rst_wait_rd_data", 64'(wb_if.rd_data), 64'd0);

        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 5'((i % 31) + 1), 32'(i * 3 + 1), 3'd0, 2'd0, 1'b0, 32'd0);
            @(negedge clk); ret++;
            chk("burst_rd_address", 64'(wb_if.rd_address), 64'((i % 31) + 1));
            chk("burst_rd_data",    64'(wb_if.rd_data),    64'(i * 3 + 1));
        end
        idle();
        @(negedge clk);
        chk("wrap_instret", 64'(wb_if.instret), 64'(exp_instret()));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage and sole driver of the register file write port. Accepts completed instructions from the memory stage and waits for load data when the memory response is late. Sign- or zero-extends load data, then presents one registered write per instruction on rd_address/rd_data. Holds rd_address at 0 in every non-writing cycle, because the register file writes unconditionally on every clock edge.

Parameters:
RETIRE_WIDTH, 64, width of the retired-instruction counter; wraps modulo 2^RETIRE_WIDTH.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
valid_in  input  1  memory stage presents an instruction this cycle
rd_address_in  input  5  destination register; 0 means no write
result_in  input  32  ALU/CSR result for non-load instructions
load_in  input  1  instruction is a load
load_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
load_addr_lsb  input  2  low address bits of the load
mem_rvalid  input  1  load data valid this cycle
mem_rdata  input  32  raw aligned word from memory
busy_out  output  1  combinational; high while in WAIT_LOAD; upstream must hold all inputs stable
rd_address  output  5  register file write address (registered)
rd_data  output  32  register file write data (registered)
instret  output  RETIRE_WIDTH  retired-instruction count

Behaviour:
- Reset values: rd_address=0, rd_data=0, instret=0, state ACCEPT, busy_out=0.
- States: ACCEPT, WAIT_LOAD. busy_out = (state==WAIT_LOAD).
- ACCEPT, valid_in=0: next cycle rd_address=0, rd_data holds its previous value.
- ACCEPT, valid_in=1, load_in=0: next cycle rd_address=rd_address_in, rd_data=result_in. Latency 1. Instruction retires.
- ACCEPT, valid_in=1, load_in=1, mem_rvalid=1: same as above but rd_data=extend(mem_rdata). Latency 1.
- ACCEPT, valid_in=1, load_in=1, mem_rvalid=0: latch rd_address_in, load_funct3 and load_addr_lsb; go to WAIT_LOAD; rd_address=0 next cycle.
- WAIT_LOAD, mem_rvalid=0: stay; rd_address=0. valid_in is ignored and not accepted.
- WAIT_LOAD, mem_rvalid=1: next cycle rd_address=latched rd, rd_data=extend(mem_rdata); go to ACCEPT; instruction retires. A new instruction is accepted no earlier than the cycle after this one.
- mem_rvalid in ACCEPT without a valid load is ignored.
- Extension:
  - byte = mem_rdata[8*lsb+7 : 8*lsb]
  - half = mem_rdata[16*lsb[1]+15 : 16*lsb[1]]; lsb[0] is ignored for halfwords
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through
  - undefined funct3 (011, 11x) is treated as LW
  - alignment is guaranteed upstream
- rd_address_in=0: rd_address stays 0 but the instruction still retires; rd_data is don't-care.
- instret increments by 1 in the cycle the registered write is produced (rd_address becomes visible on the following edge), including rd=0 writes. It wraps from all-ones to 0.
- Reset during WAIT_LOAD: the pending load is abandoned; a mem_rvalid coinciding with reset is ignored; the state after reset is ACCEPT with no write.

Optional Feature:
RETIRE_COUNTER_EN: when defined, instret is implemented as specified. When undefined, no counter flops are built and instret is tied to 0. All other behaviour is identical.

Test Plan:
- Reset then idle 3 cycles -> rd_address=0, rd_data=0, busy_out=0, instret=0 throughout.
- valid_in=1, load_in=0, rd=5, result=0xDEADBEEF -> next cycle rd_address=5, rd_data=0xDEADBEEF; cycle after rd_address=0; instret=1.
- LB with lsb=3, mem_rdata=0x80FF_0000 in the same cycle -> rd_data=0xFFFFFF80. LHU with lsb=2 -> 0x000080FF. LH with lsb=2 -> 0xFFFF80FF.
- LW rd=7, mem_rvalid delayed 4 cycles, mem_rdata=0x12345678 -> busy_out high for 4 cycles with rd_address=0; then rd_address=7, rd_data=0x12345678; busy_out low.
- Reset asserted in the 2nd WAIT_LOAD cycle together with mem_rvalid=1 -> no write ever appears for that load; state ACCEPT; instret=0.
- With RETIRE_COUNTER_EN: preload near wrap (RETIRE_WIDTH=4) and retire 17 instructions -> instret=1. Without the macro -> instret=0.
